// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Stalls EX while busy, returns {remainder, quotient}.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_start,
  input  logic                div_signed,
  input  logic [DATA_W-1:0]   dividend,
  input  logic [DATA_W-1:0]   divisor,
  input  logic                div_annul,
  output logic                stallreq_for_ex,
  output logic                div_ready,
  output logic [2*DATA_W-1:0] div_result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DZERO = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // {rem, quo}; the top bit of the 65-bit
  // working value is always 0 between steps
  logic [2*DATA_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                sgn_a_q, sgn_a_d;
  logic                sgn_b_q, sgn_b_d;
  logic [2*DATA_W-1:0] res_q, res_d;

  logic                neg_a, neg_b;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [2*DATA_W:0]   sh;
  logic [DATA_W:0]     trial;
  logic [2*DATA_W-1:0] step;
  logic [DATA_W-1:0]   q_raw, r_raw;
  logic [DATA_W-1:0]   q_fix, r_fix;

  // operand magnitudes and signs seen at start
  always_comb begin
    neg_a = div_signed & dividend[DATA_W-1];
    neg_b = div_signed & divisor[DATA_W-1];
    mag_a = neg_a ? (~dividend + 1'b1) : dividend;
    mag_b = neg_b ? (~divisor + 1'b1) : divisor;
  end

  // one restoring step plus sign fix-up
  always_comb begin
    sh    = {wr_q, 1'b0};
    trial = sh[2*DATA_W:DATA_W] - {1'b0, dvs_q};
    if (!trial[DATA_W]) begin
      step = {trial[DATA_W-1:0],
              sh[DATA_W-1:1], 1'b1};
    end else begin
      step = sh[2*DATA_W-1:0];
    end
    q_raw = step[DATA_W-1:0];
    r_raw = step[2*DATA_W-1:DATA_W];
    q_fix = (sgn_a_q ^ sgn_b_q)
          ? (~q_raw + 1'b1) : q_raw;
    r_fix = sgn_a_q ? (~r_raw + 1'b1) : r_raw;
  end

  // next-state, counter and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    dvs_d   = dvs_q;
    sgn_a_d = sgn_a_q;
    sgn_b_d = sgn_b_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (div_start && !div_annul) begin
          cnt_d = '0;
          if (divisor == '0) begin
            wr_d    = {{DATA_W{1'b0}}, dividend};
            state_d = S_DZERO;
          end else begin
            wr_d    = {{DATA_W{1'b0}}, mag_a};
            dvs_d   = mag_b;
            sgn_a_d = neg_a;
            sgn_b_d = neg_b;
            state_d = S_ON;
          end
        end
      end
      S_DZERO: begin
        if (div_annul) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          res_d   = {wr_q[DATA_W-1:0],
                     {DATA_W{1'b1}}};
          state_d = S_END;
        end
      end
      S_ON: begin
        if (div_annul) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          wr_d  = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            res_d   = {r_fix, q_fix};
            state_d = S_END;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      dvs_q   <= '0;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      dvs_q   <= dvs_d;
      sgn_a_q <= sgn_a_d;
      sgn_b_q <= sgn_b_d;
      res_q   <= res_d;
    end
  end

  // stall while a division is pending, not in END
  always_comb begin
    stallreq_for_ex = rst & div_start & ~div_annul
                    & (state_q != S_END);
    div_ready  = (state_q == S_END);
    div_result = res_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table
// plus annul, back-to-back and reset sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_annul;
  logic        stallreq_for_ex;
  logic        div_ready;
  logic [63:0] div_result;

  int ncmp = 0;
  int nbad = 0;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vt [0:10];

  div_unit dut (
    .clk             (clk),
    .rst             (rst),
    .div_start       (div_start),
    .div_signed      (div_signed),
    .dividend        (dividend),
    .divisor         (divisor),
    .div_annul       (div_annul),
    .stallreq_for_ex (stallreq_for_ex),
    .div_ready       (div_ready),
    .div_result      (div_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at cycle 0 (just after a posedge).
  // Returns just after the edge ending cycle lat.
  task automatic run(input vec_t v,
                     input bit drop);
    int bad_s;
    int rdy_c;
    logic [63:0] got;
    bad_s = 0;
    rdy_c = -1;
    got   = '0;
    div_start  = 1'b1;
    div_signed = v.sgn;
    dividend   = v.a;
    divisor    = v.b;
    for (int c = 0; c <= v.lat; c++) begin
      @(negedge clk);
      if (stallreq_for_ex !== (c < v.lat))
        bad_s++;
      if (div_ready === 1'b1 && rdy_c < 0)
        rdy_c = c;
      if (c == v.lat) got = div_result;
      tick();
    end
    check({v.name, " stall"}, 64'(bad_s), 64'd0);
    check({v.name, " rdy_cyc"}, 64'(rdy_c),
          64'(v.lat));
    check({v.name, " result"}, got, v.exp);
    if (drop) begin
      div_start = 1'b0;
      @(negedge clk);
      check({v.name, " idle_rdy"},
            64'(div_ready), 64'd0);
      check({v.name, " idle_res"},
            div_result, v.exp);
      tick();
    end
  endtask

  initial begin
    vec_t v;
    int   rdy_seen;
    vt[0]  = '{"divu_7_2", 1'b0, 32'd7, 32'd2,
               64'h00000001_00000003, 33};
    vt[1]  = '{"div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
               64'hFFFFFFFF_FFFFFFFD, 33};
    vt[2]  = '{"div_ovf", 1'b1, 32'h80000000,
               32'hFFFFFFFF,
               64'h00000000_80000000, 33};
    vt[3]  = '{"divu_5_0", 1'b0, 32'd5, 32'd0,
               64'h00000005_FFFFFFFF, 2};
    vt[4]  = '{"divu_100_3", 1'b0, 32'd100, 32'd3,
               64'h00000001_00000021, 33};
    vt[5]  = '{"divu_max_1", 1'b0, 32'hFFFFFFFF,
               32'd1, 64'h00000000_FFFFFFFF, 33};
    vt[6]  = '{"div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
               64'h00000001_FFFFFFFD, 33};
    vt[7]  = '{"div_m8_0", 1'b1, 32'hFFFFFFF8, 32'd0,
               64'hFFFFFFF8_FFFFFFFF, 2};
    vt[8]  = '{"divu_3_10", 1'b0, 32'd3, 32'd10,
               64'h00000003_00000000, 33};
    vt[9]  = '{"divu_max_max", 1'b0, 32'hFFFFFFFF,
               32'hFFFFFFFF,
               64'h00000000_00000001, 33};
    vt[10] = '{"div_m100_m7", 1'b1, 32'hFFFFFF9C,
               32'hFFFFFFF9,
               64'hFFFFFFFE_0000000E, 33};

    rst        = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    div_annul  = 1'b0;
    #12;
    check("rst_stall", 64'(stallreq_for_ex), 64'd0);
    check("rst_ready", 64'(div_ready), 64'd0);
    check("rst_result", div_result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i <= 10; i++) run(vt[i], 1'b1);

    // annul at cycle 10 of a 100/3
    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd3;
    rdy_seen   = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (div_ready === 1'b1) rdy_seen++;
      tick();
    end
    div_annul = 1'b1;
    @(negedge clk);
    check("annul_stall", 64'(stallreq_for_ex), 64'd0);
    tick();
    div_annul = 1'b0;
    div_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (div_ready === 1'b1) rdy_seen++;
      tick();
    end
    check("annul_no_rdy", 64'(rdy_seen), 64'd0);
    check("annul_res_held", div_result, vt[10].exp);
    v = vt[4];
    v.name = "after_annul";
    run(v, 1'b1);

    // annul with start in IDLE holds IDLE
    div_start = 1'b1;
    div_annul = 1'b1;
    dividend  = 32'd9;
    divisor   = 32'd4;
    rdy_seen  = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (stallreq_for_ex !== 1'b0) rdy_seen++;
      if (div_ready !== 1'b0) rdy_seen++;
      tick();
    end
    check("idle_annul", 64'(rdy_seen), 64'd0);
    div_annul = 1'b0;

    // back-to-back 9/4 then 10/3
    v = '{"b2b_9_4", 1'b0, 32'd9, 32'd4,
          64'h00000001_00000002, 33};
    run(v, 1'b0);
    v = '{"b2b_10_3", 1'b0, 32'd10, 32'd3,
          64'h00000001_00000003, 33};
    run(v, 1'b1);

    // async reset at cycle 15
    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd7;
    divisor    = 32'd2;
    for (int c = 0; c < 15; c++) tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_stall", 64'(stallreq_for_ex), 64'd0);
    check("arst_ready", 64'(div_ready), 64'd0);
    check("arst_result", div_result, 64'd0);
    tick();
    tick();
    div_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    v = vt[0];
    v.name = "after_rst";
    run(v, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit radix-2 restoring divider for DIV/DIVU in the EX stage.
- Generates `stallreq_for_ex` toward the pipeline stall controller while a division is in flight.
- Delivers `{remainder, quotient}` for the HI/LO write path.
- Upstream producer of the EX stall request. The stall controller freezes IF..EX while the request is high, so EX holds `div_start` and the operands stable.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.
- CNT_W, 6, width of the iteration counter (must hold DATA_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- div_start  input  1  EX holds a valid DIV/DIVU; held high until `div_ready` is seen.
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with `div_start` in IDLE.
- dividend  input  DATA_W  operand rs; sampled in IDLE.
- divisor  input  DATA_W  operand rt; sampled in IDLE.
- div_annul  input  1  flush/exception cancel of the in-flight division.
- stallreq_for_ex  output  1  stall request to the stall controller.
- div_ready  output  1  one-cycle pulse: `div_result` is valid this cycle.
- div_result  output  2*DATA_W  `{remainder, quotient}`; [63:32] goes to HI, [31:0] goes to LO.

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, partial-remainder register=0, `div_ready`=0, `div_result`=0, `stallreq_for_ex`=0.
- States: IDLE, DZERO, ON, END. State, counter, datapath and result registers update on the rising clk edge.
- `stallreq_for_ex` is combinational:
  - equals `div_start & ~div_annul` in IDLE, DZERO and ON;
  - 0 in END.
- `div_ready` is registered-state decoded: 1 only in END.
- IDLE:
  - `div_start=1`, `div_annul=0`, divisor==0: go to DZERO.
  - `div_start=1`, `div_annul=0`, divisor!=0: latch magnitudes (negate a negative operand if `div_signed`), latch the two sign bits, clear the counter, go to ON.
  - Otherwise stay in IDLE.
- ON:
  - Each cycle performs one restoring step on a 65-bit working register `{rem, quo}`:
    - shift left by 1;
    - trial-subtract the divisor magnitude from the upper 33 bits;
    - if the result is non-negative, keep the difference and set quo[0]=1; else restore and set quo[0]=0.
  - The counter increments each step; after the step at counter==DATA_W-1, go to END.
  - On entry to END, apply sign fix-up (only when `div_signed`):
    - quotient is negated if the sign bits differ;
    - remainder takes the dividend's sign.
  - The fixed-up values are registered into `div_result`.
- DZERO (one cycle): load `div_result = {dividend, 32'hFFFF_FFFF}` (raw dividend as remainder), then go to END.
- END (exactly one cycle): `div_ready`=1 and `stallreq_for_ex`=0, so the pipeline advances on this edge. Next state is always IDLE, regardless of `div_start`.
- Back-to-back divisions: the second DIV reaches EX in the cycle after END, finds IDLE, and starts normally. No dead cycle beyond IDLE.
- Latency (cycle 0 = first cycle `div_start`=1 in IDLE):
  - Normal: ON covers cycles 1..32, END is cycle 33. `stallreq_for_ex` is high for cycles 0..32 (33 cycles).
  - Divide by zero: DZERO is cycle 1, END is cycle 2.
- `div_annul=1` in any state except IDLE: next state IDLE, counter cleared, no `div_ready` pulse, `div_result` unchanged. `stallreq_for_ex` drops combinationally in the same cycle.
- `div_annul` and `div_start` together in IDLE: stay in IDLE.
- `div_result` holds its last value outside END. Consumers must qualify it with `div_ready`.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No trap; this falls out of the magnitude arithmetic.
- Operand changes after IDLE are ignored; operands are latched at start.
- Reset mid-operation: immediate return to the reset values above.

Test Plan:
- DIVU 7/2, `div_start` held: `stallreq_for_ex`=1 for cycles 0..32; cycle 33 `div_ready`=1, `div_result`=0x00000001_00000003; cycle 34 back in IDLE.
- DIV -7/2 (0xFFFFFFF9/0x2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, ready at cycle 33. Then DIV 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0.
- DIVU 5/0: `div_ready` at cycle 2, `div_result`=0x00000005_FFFFFFFF, `stallreq_for_ex` high for cycles 0..1 only.
- `div_annul` pulsed at cycle 10 of a 100/3 DIVU: `stallreq_for_ex`=0 in cycle 10, IDLE at cycle 11, no `div_ready`, `div_result` keeps its old value. A new DIVU 100/3 then gives 0x00000001_00000021.
- Back-to-back DIVU 9/4 then 10/3 (second start asserted in the cycle after END): results 0x00000001_00000002 at cycle 33 and 0x00000001_00000003 at cycle 67.
- rst driven low at cycle 15 of a division, asynchronously: all outputs 0 immediately. After release, a fresh 7/2 completes normally in 33 cycles.
